nonce_result_queue: RTL and testbench
=====================================

# nonce_result_queue

Parametrised successor to the single-hit nonce decoder. Sits between the hashing core array and the host result path: it tracks the round index of every valid result cycle, converts each core's success flag into a full 32-bit nonce, and buffers rounds with hits in a FIFO. Multiple simultaneous hits are emitted one nonce per cycle over a ready/valid handshake, lowest core index first. It also flushes on a new block and reports overflow and nonce-space exhaustion.

## Interface
- NUM_CORES, 4: cores in the array; power of two, 2..256; IDXW = log2(NUM_CORES)
- DEPTH, 4: FIFO entries, each holding one round with at least one hit; power of two, ≥2
- RW (derived), 32-IDXW: round counter width

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- newblock_i  in  1  single-cycle strobe: start of a new block header
- valid_i  in  1  success_i carries one round of results this cycle
- success_i  in  NUM_CORES  bit k = core k found a hit this round
- ready_i  in  1  downstream accepts nonce_o this cycle
- valid_o  out  1  nonce_o is valid
- nonce_o  out  32  decoded nonce = {round[RW-1:0], k[IDXW-1:0]}
- overflow_o  out  1  sticky: a round with hits was dropped because the FIFO was full
- exhausted_o  out  1  sticky: final round 2^RW-1 has been processed
- count_o  out  log2(DEPTH)+1  occupied FIFO entries

## Operation
- Round counter `round` (RW bits) starts at 0 after reset or newblock_i. It increments on every accepted valid_i cycle, whether or not there were hits.
- Accepted valid_i with success_i != 0: push {round, success_i} into the FIFO. Rounds with success_i == 0 only advance `round`.
- Head entry drives the output. k = lowest set bit of the head's residual mask; valid_o = FIFO not empty; nonce_o = {head.round, k}.
- valid_o & ready_i: clear bit k in the head mask. If the mask becomes zero, pop the head.
- Full FIFO: a push is allowed in the same cycle the head pops. Otherwise the incoming round is dropped, overflow_o is set, and `round` still increments.
- Exhaustion: when valid_i is accepted with round == 2^RW-1, set exhausted_o and freeze `round`. Further valid_i cycles are ignored: no push, no increment. Already-queued entries still drain.
- newblock_i: flushes the FIFO (count 0), clears `round`, overflow_o and exhausted_o.
- newblock_i with valid_i in the same cycle: that round is round 0 of the new block. It is pushed into the emptied FIFO if it has hits, and `round` becomes 1.
- valid_o never depends combinationally on ready_i. nonce_o is held stable while valid_o & !ready_i.

## Timing
- Reset values: valid_o 0, nonce_o 0, overflow_o 0, exhausted_o 0, count_o 0; internal `round` 0, FIFO empty.
- Latency: valid_i with hits sampled at edge N gives valid_o high from edge N (registered FIFO state) and visible in the following cycle if the FIFO was empty.
- Throughput: one nonce per cycle with ready_i held high. A round with h hits occupies the head for h consecutive accepting cycles.
- newblock_i at edge N: valid_o is 0 in the following cycle unless the same-cycle valid_i round had hits.
- count_o updates on the same edge as the push/pop.
- rst asserted mid-drain: all state clears immediately, with no partial emission.

## Test plan
- NUM_CORES=4, DEPTH=4. Reset, newblock_i, then valid_i for 3 cycles with success_i = 0000, 0100, 0000 and ready_i=1 -> exactly one nonce 0x00000006 (round 1, core 2), valid_o high for 1 cycle, count_o returns to 0.
- One round, success_i=1011 at round 5, ready_i=1 -> nonces 0x14, 0x15, 0x17 on 3 consecutive cycles. Then repeat with ready_i=0 for 4 cycles first -> nonce_o held at 0x14 throughout the stall.
- ready_i=0; 5 consecutive valid_i rounds, each success_i=0001 -> count_o saturates at 4, overflow_o=1, round 4 dropped. Release ready_i -> nonces 0x00, 0x04, 0x08, 0x0C.
- FIFO full with ready_i=1 and the head mask at one bit, while valid_i brings hits -> push and pop in the same cycle, count_o stays 4, overflow_o stays 0.
- Preload `round` near the limit by running 2^30 rounds (or force round=2^30-1 in a reduced-width build), success_i=1000 -> nonce 0xFFFFFFFF, exhausted_o=1. A further valid_i with 1111 produces no output.
- Entries queued plus newblock_i with valid_i and success_i=0010 in the same cycle -> old entries discarded, next nonce 0x00000001, overflow_o and exhausted_o cleared. Also assert rst mid-drain -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/nonce_result_queue.sv
// rtl/nonce_result_queue.sv - hit-round FIFO that turns core success flags into 32-bit nonces
//
// Tracks the round index of every accepted result cycle. Rounds with at least
// one hit are buffered as {round, mask}. The head is emitted one nonce per
// accepted handshake, lowest core index first.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   newblock_i   strobe: flush FIFO, clear round counter and sticky flags
//   valid_i      success_i carries one round of results this cycle
//   success_i    per-core hit flags for the current round
//   ready_i      downstream accepts nonce_o this cycle
//   valid_o      nonce_o is valid (FIFO not empty)
//   nonce_o      {head round, lowest set core index of head mask}
//   overflow_o   sticky: a round with hits was dropped on a full FIFO
//   exhausted_o  sticky: the last representable round has been processed
//   count_o      number of occupied FIFO entries
module nonce_result_queue #(
  parameter int NUM_CORES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   newblock_i,
  input  logic                   valid_i,
  input  logic [NUM_CORES-1:0]   success_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [31:0]            nonce_o,
  output logic                   overflow_o,
  output logic                   exhausted_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int IDXW = $clog2(NUM_CORES);
  localparam int RW   = 32 - IDXW;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [RW-1:0] ROUND_LAST = {RW{1'b1}};
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [RW-1:0]        fifo_round_q [DEPTH];
  logic [NUM_CORES-1:0] fifo_mask_q  [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] round_q, round_d;
  logic          overflow_q, overflow_d;
  logic          exhausted_q, exhausted_d;

  logic [NUM_CORES-1:0] head_mask;
  logic [NUM_CORES-1:0] residual_mask;
  logic [RW-1:0]        head_round;
  logic [IDXW-1:0]      head_idx;
  logic                 not_empty;

  // Values as seen after a same-cycle newblock_i flush; a newblock round is
  // processed as round 0 of an empty queue.
  logic [RW-1:0] base_round;
  logic [PW-1:0] base_rd, base_wr;
  logic [CW-1:0] base_count;
  logic          base_exh, base_ovf;

  logic accept, push_req, push, fire, pop, full;

  assign head_mask  = fifo_mask_q[rd_ptr_q];
  assign head_round = fifo_round_q[rd_ptr_q];
  assign not_empty  = (count_q != '0);

  // Lowest set bit of the head mask: scanning downward lets the lowest hit win.
  always_comb begin
    head_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (head_mask[i]) head_idx = IDXW'(i);
    end
  end

  assign residual_mask = head_mask & ~(NUM_CORES'(1) << head_idx);

  always_comb begin
    base_round = newblock_i ? '0 : round_q;
    base_rd    = newblock_i ? '0 : rd_ptr_q;
    base_wr    = newblock_i ? '0 : wr_ptr_q;
    base_count = newblock_i ? '0 : count_q;
    base_exh   = newblock_i ? 1'b0 : exhausted_q;
    base_ovf   = newblock_i ? 1'b0 : overflow_q;

    accept   = valid_i & ~base_exh;
    push_req = accept & (|success_i);
    // A flush discards the head, so no handshake completes on a newblock cycle.
    fire     = not_empty & ready_i & ~newblock_i;
    pop      = fire & ~(|residual_mask);
    full     = (base_count == FULL_COUNT);
    // A full queue still takes the new round when the head leaves this cycle.
    push     = push_req & (~full | pop);

    round_d     = base_round;
    exhausted_d = base_exh;
    if (accept) begin
      if (base_round == ROUND_LAST) exhausted_d = 1'b1;
      else                          round_d     = base_round + RW'(1);
    end

    overflow_d = base_ovf | (push_req & ~push);
    rd_ptr_d   = base_rd + PW'(pop);
    wr_ptr_d   = base_wr + PW'(push);
    count_d    = base_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      round_q     <= '0;
      overflow_q  <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      round_q     <= round_d;
      overflow_q  <= overflow_d;
      exhausted_q <= exhausted_d;
    end
  end

  // Storage needs no reset: it is only observed through occupied entries.
  // The push slot never coincides with a partially drained head (push into
  // the head slot only happens when empty or when the head pops).
  always_ff @(posedge clk) begin
    if (fire && (|residual_mask)) begin
      fifo_mask_q[rd_ptr_q] <= residual_mask;
    end
    if (push) begin
      fifo_round_q[base_wr] <= base_round;
      fifo_mask_q[base_wr]  <= success_i;
    end
  end

  assign valid_o     = not_empty;
  assign nonce_o     = not_empty ? {head_round, head_idx} : 32'd0;
  assign overflow_o  = overflow_q;
  assign exhausted_o = exhausted_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_nonce_result_queue.sv
// tb/tb_nonce_result_queue.sv - scoreboard bench for nonce_result_queue
module tb_nonce_result_queue;

  logic        clk;
  logic        rst;
  logic        newblock_i;
  logic        valid_i;
  logic [3:0]  success_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] nonce_o;
  logic        overflow_o;
  logic        exhausted_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vcount = 0;
  int hs_first = -1;
  int hs_last = -1;
  logic [31:0] sb[$];

  nonce_result_queue #(.NUM_CORES(4), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .newblock_i  (newblock_i),
    .valid_i     (valid_i),
    .success_i   (success_i),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .nonce_o     (nonce_o),
    .overflow_o  (overflow_o),
    .exhausted_o (exhausted_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then score any handshake
  // that the next rising edge will complete.
  task automatic cycle(input logic nb, input logic v, input logic [3:0] s, input logic r);
    @(negedge clk);
    newblock_i = nb;
    valid_i    = v;
    success_i  = s;
    ready_i    = r;
    cyc++;
    #1;
    if (valid_o) vcount++;
    if (nb) begin
      sb.delete();
    end else if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("extra_nonce_valid", 32'(valid_o), 32'd0);
      end else begin
        check("nonce", nonce_o, sb.pop_front());
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
    end
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    check("drain_left", 32'(sb.size()), 32'd0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    newblock_i = 1'b0;
    valid_i = 1'b0;
    success_i = 4'b0000;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_nonce", nonce_o, 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_exhausted", 32'(exhausted_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    rst = 1'b0;

    // single hit at round 1, core 2
    vcount = 0;
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b1, 4'b0000, 1'b1);
    cycle(1'b0, 1'b1, 4'b0100, 1'b1);
    sb.push_back(32'h0000_0006);
    cycle(1'b0, 1'b1, 4'b0000, 1'b1);
    drain(10);
    check("t1_valid_cycles", 32'(vcount), 32'd1);
    check("t1_count", 32'(count_o), 32'd0);

    // three hits in round 5, streamed back to back
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    repeat (5) cycle(1'b0, 1'b1, 4'b0000, 1'b1);
    vcount = 0;
    hs_first = -1;
    cycle(1'b0, 1'b1, 4'b1011, 1'b1);
    sb.push_back(32'h14);
    sb.push_back(32'h15);
    sb.push_back(32'h17);
    drain(10);
    check("t2_valid_cycles", 32'(vcount), 32'd3);
    check("t2_span", 32'(hs_last - hs_first), 32'd2);

    // same round held under back-pressure
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 4'b1011, 1'b0);
    sb.push_back(32'h14);
    sb.push_back(32'h15);
    sb.push_back(32'h17);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 4'b0000, 1'b0);
      check("t2_stall_valid", 32'(valid_o), 32'd1);
      check("t2_stall_nonce", nonce_o, 32'h14);
    end
    drain(10);

    // overflow: five hit rounds into a four-deep stalled queue
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int r = 0; r < 5; r++) begin
      cycle(1'b0, 1'b1, 4'b0001, 1'b0);
      if (r < 4) sb.push_back(32'(r * 4));
    end
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check("t3_count_full", 32'(count_o), 32'd4);
    check("t3_overflow", 32'(overflow_o), 32'd1);
    drain(20);
    check("t3_overflow_sticky", 32'(overflow_o), 32'd1);

    // full queue: push and pop on the same edge
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int r = 0; r < 4; r++) begin
      cycle(1'b0, 1'b1, 4'b0001, 1'b0);
      sb.push_back(32'(r * 4));
    end
    cycle(1'b0, 1'b1, 4'b0010, 1'b1);
    sb.push_back(32'h11);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check("t4_count", 32'(count_o), 32'd4);
    check("t4_overflow", 32'(overflow_o), 32'd0);
    drain(20);

    // exhaustion at the last round
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    force dut.round_q = 30'h3FFF_FFFF;
    cycle(1'b0, 1'b1, 4'b1000, 1'b1);
    sb.push_back(32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    release dut.round_q;
    check("t5_exhausted", 32'(exhausted_o), 32'd1);
    cycle(1'b0, 1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    check("t5_count", 32'(count_o), 32'd0);
    check("t5_valid", 32'(valid_o), 32'd0);
    check("t5_exhausted_sticky", 32'(exhausted_o), 32'd1);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // newblock with a same-cycle hit round clears everything
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int r = 0; r < 5; r++) begin
      cycle(1'b0, 1'b1, 4'b0001, 1'b0);
      if (r < 4) sb.push_back(32'(r * 4));
    end
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    force dut.round_q = 30'h3FFF_FFFF;
    cycle(1'b0, 1'b1, 4'b1000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    release dut.round_q;
    check("t6_pre_count", 32'(count_o), 32'd4);
    check("t6_pre_overflow", 32'(overflow_o), 32'd1);
    check("t6_pre_exhausted", 32'(exhausted_o), 32'd1);
    check("t6_pre_nonce", nonce_o, 32'h0);
    cycle(1'b1, 1'b1, 4'b0010, 1'b0);
    sb.push_back(32'h0000_0001);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check("t6_count", 32'(count_o), 32'd1);
    check("t6_overflow", 32'(overflow_o), 32'd0);
    check("t6_exhausted", 32'(exhausted_o), 32'd0);
    check("t6_valid", 32'(valid_o), 32'd1);
    check("t6_nonce", nonce_o, 32'h0000_0001);
    drain(10);
    cycle(1'b0, 1'b1, 4'b0100, 1'b0);
    sb.push_back(32'h0000_0006);
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check("t6_nb_valid", 32'(valid_o), 32'd0);
    check("t6_nb_count", 32'(count_o), 32'd0);

    // asynchronous reset in the middle of a drain
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 4'b1011, 1'b0);
    sb.push_back(32'h0);
    sb.push_back(32'h1);
    sb.push_back(32'h3);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    check("t7_mid_nonce", nonce_o, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("t7_rst_valid", 32'(valid_o), 32'd0);
    check("t7_rst_nonce", nonce_o, 32'd0);
    check("t7_rst_count", 32'(count_o), 32'd0);
    check("t7_rst_overflow", 32'(overflow_o), 32'd0);
    check("t7_rst_exhausted", 32'(exhausted_o), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    check("t7_post_valid", 32'(valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
